// File: rtl/keys_switches_interface_pkg.sv
// Shared constants for the keys/switches peripheral: bus addresses, default
// input counts and bit positions of each field in the two read words.
package keys_switches_interface_pkg;

    localparam logic ADDR_LEVEL = 1'b0;
    localparam logic ADDR_EVENT = 1'b1;

    localparam int DEFAULT_NUM_SW  = 18;
    localparam int DEFAULT_NUM_KEY = 4;

    localparam int WORD_W      = 32;
    localparam int SW_LSB      = 0;
    localparam int KEY_LSB     = 18;
    localparam int PRESS_LSB   = 0;
    localparam int RELEASE_LSB = 4;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/keys_switches_interface_debounce_cell.sv
// Per-input debouncer: shifts in one sample per tick and adopts the sampled
// value only once the last three samples agree.
module debounce_cell (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic sync_in,
    output logic db_out
);

    logic [2:0] samples_reg;
    logic       db_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            samples_reg <= 3'b000;
            db_reg      <= 1'b0;
        end else begin
            if (tick) begin
                samples_reg <= {samples_reg[1:0], sync_in};
            end
            // Disagreeing samples leave the debounced value untouched.
            if (&samples_reg) begin
                db_reg <= 1'b1;
            end else if (~|samples_reg) begin
                db_reg <= 1'b0;
            end
        end
    end

    assign db_out = db_reg;

endmodule

// File: rtl/keys_switches_interface.sv
// Slide-switch / pushbutton read port: synchronise, debounce, latch key events
// as sticky write-1-to-clear bits. Define RELEASE_EVENT_EN to add release events.
module keys_switches_interface
    import keys_switches_interface_pkg::*;
#(
    parameter int TICK_CYCLES = 250000,
    parameter int NUM_SW      = DEFAULT_NUM_SW,
    parameter int NUM_KEY     = DEFAULT_NUM_KEY
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SW-1:0]  SW,
    input  logic [NUM_KEY-1:0] KEY,
    input  logic               read_enable,
    input  logic               write_enable,
    input  logic               address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CNT_W-1:0]   tick_count_reg;
    logic               tick;
    logic [NUM_SW-1:0]  sw_meta_reg, sw_sync_reg, sw_db;
    logic [NUM_KEY-1:0] key_meta_reg, key_sync_reg, key_pressed, key_db;
    logic [NUM_KEY-1:0] key_db_prev_reg;
    logic [NUM_KEY-1:0] press_pend_reg, press_pend_next, press_rise, press_clr;
    logic [NUM_KEY-1:0] release_pend;
    logic               event_write;
    word_t              level_word, event_word, read_data_reg;
    logic               unused_write_data;

    assign tick = (tick_count_reg == CNT_W'(TICK_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_count_reg <= '0;
        end else if (tick) begin
            tick_count_reg <= '0;
        end else begin
            tick_count_reg <= tick_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            key_meta_reg <= '0;
            key_sync_reg <= '0;
        end else begin
            sw_meta_reg  <= SW;
            sw_sync_reg  <= sw_meta_reg;
            key_meta_reg <= KEY;
            key_sync_reg <= key_meta_reg;
        end
    end

    // Buttons are active-low on the board; everything downstream sees pressed = 1.
    assign key_pressed = ~key_sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SW; gi++) begin : g_sw_db
            debounce_cell u_cell (
                .clock   (clock),
                .reset   (reset),
                .tick    (tick),
                .sync_in (sw_sync_reg[gi]),
                .db_out  (sw_db[gi])
            );
        end
        for (gi = 0; gi < NUM_KEY; gi++) begin : g_key_db
            debounce_cell u_cell (
                .clock   (clock),
                .reset   (reset),
                .tick    (tick),
                .sync_in (key_pressed[gi]),
                .db_out  (key_db[gi])
            );
        end
    endgenerate

    assign event_write = write_enable && (address == ADDR_EVENT);
    assign press_rise  = key_db & ~key_db_prev_reg;
    assign press_clr   = event_write ? write_data[PRESS_LSB +: NUM_KEY] : '0;
    // A new edge in the same cycle as its clear keeps the bit set.
    assign press_pend_next = (press_pend_reg & ~press_clr) | press_rise;

    always_ff @(posedge clock) begin
        if (reset) begin
            key_db_prev_reg <= '0;
            press_pend_reg  <= '0;
        end else begin
            key_db_prev_reg <= key_db;
            press_pend_reg  <= press_pend_next;
        end
    end

`ifdef RELEASE_EVENT_EN
    logic [NUM_KEY-1:0] release_pend_reg, release_pend_next, release_fall, release_clr;

    assign release_fall      = ~key_db & key_db_prev_reg;
    assign release_clr       = event_write ? write_data[RELEASE_LSB +: NUM_KEY] : '0;
    assign release_pend_next = (release_pend_reg & ~release_clr) | release_fall;

    always_ff @(posedge clock) begin
        if (reset) begin
            release_pend_reg <= '0;
        end else begin
            release_pend_reg <= release_pend_next;
        end
    end

    assign release_pend = release_pend_reg;
`else
    assign release_pend = '0;
`endif

    always_comb begin
        level_word = '0;
        event_word = '0;
        level_word[SW_LSB +: NUM_SW]       = sw_db;
        level_word[KEY_LSB +: NUM_KEY]     = key_db;
        event_word[PRESS_LSB +: NUM_KEY]   = press_pend_reg;
        event_word[RELEASE_LSB +: NUM_KEY] = release_pend;
    end

    // Reads sample the pre-clear pending bits, so a read-and-clear returns them.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_data_reg <= '0;
        end else if (read_enable) begin
            read_data_reg <= (address == ADDR_EVENT) ? event_word : level_word;
        end
    end

    assign read_data         = read_data_reg;
    assign unused_write_data = ^write_data;

endmodule

// File: tb/tb_keys_switches_interface.sv
// Self-checking bench for keys_switches_interface (TICK_CYCLES = 4); honours
// RELEASE_EVENT_EN when the design is built with it.
module tb_keys_switches_interface;

    localparam int TICK   = 4;
    localparam int SETTLE = 24;

    logic        clock = 1'b0;
    logic        reset;
    logic [17:0] SW;
    logic [3:0]  KEY;
    logic        read_enable, write_enable, address;
    logic [31:0] write_data, read_data;

    int checks   = 0;
    int failures = 0;

    keys_switches_interface #(.TICK_CYCLES(TICK), .NUM_SW(18), .NUM_KEY(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .SW           (SW),
        .KEY          (KEY),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic bus_read(input logic a, output logic [31:0] d);
        read_enable = 1'b1;
        address     = a;
        step();
        read_enable = 1'b0;
        d           = read_data;
    endtask

    task automatic bus_write(input logic a, input logic [31:0] v);
        write_enable = 1'b1;
        address      = a;
        write_data   = v;
        step();
        write_enable = 1'b0;
        write_data   = '0;
    endtask

    task automatic quiesce();
        KEY = 4'hF;
        wait_cycles(SETTLE);
        bus_write(1'b1, 32'hFF);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        SW    = 18'h3FFFF;
        KEY   = 4'hF;
        reset = 1'b1;
        read_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            address = i[0];
            step();
            checks++;
            if (read_data !== 32'h0) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", i, read_data, 32'h0);
            end
        end
        read_enable = 1'b0;
        reset = 1'b0;
        bus_read(1'b0, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_level: got %h expected %h", d, 32'h0);
        end
        bus_read(1'b1, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_event: got %h expected %h", d, 32'h0);
        end
    endtask

    task automatic test_switch_capture();
        logic [31:0] d;
        SW  = 18'h2A5A5;
        KEY = 4'hF;
        wait_cycles(SETTLE);
        bus_read(1'b0, d);
        checks++;
        if (d !== 32'h0002A5A5) begin
            failures++;
            $display("FAIL switch_level: got %h expected %h", d, 32'h0002A5A5);
        end
        wait_cycles(5);
        bus_read(1'b0, d);
        checks++;
        if (d !== 32'h0002A5A5) begin
            failures++;
            $display("FAIL switch_level_hold: got %h expected %h", d, 32'h0002A5A5);
        end
        KEY = 4'b1110;
        wait_cycles(SETTLE);
        bus_read(1'b0, d);
        checks++;
        if (d !== 32'h0006A5A5) begin
            failures++;
            $display("FAIL switch_key_level: got %h expected %h", d, 32'h0006A5A5);
        end
    endtask

    task automatic test_bouncy_press();
        logic [31:0] d;
        logic        prev;
        int          rises;
        SW = '0;
        quiesce();
        rises = 0;
        prev  = 1'b0;
        read_enable = 1'b1;
        address     = 1'b1;
        for (int i = 0; i < 40; i++) begin
            KEY[0] = (i < 10) ? i[0] : 1'b0;
            step();
            if (read_data[0] && !prev) rises++;
            prev = read_data[0];
        end
        read_enable = 1'b0;
        checks++;
        if (rises != 1) begin
            failures++;
            $display("FAIL bouncy_rises: got %0d expected %0d", rises, 1);
        end
        checks++;
        if (read_data !== 32'h1) begin
            failures++;
            $display("FAIL bouncy_event: got %h expected %h", read_data, 32'h1);
        end
        bus_read(1'b0, d);
        checks++;
        if (d !== 32'h00040000) begin
            failures++;
            $display("FAIL bouncy_level: got %h expected %h", d, 32'h00040000);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        int          seen;
        quiesce();
        seen = 0;
        read_enable = 1'b1;
        address     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            KEY[1] = (i >= 2 && i < 7) ? 1'b0 : 1'b1;
            step();
            if (read_data[19]) seen++;
        end
        read_enable = 1'b0;
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL glitch_level: got %0d cycles with bit19 expected %0d", seen, 0);
        end
        bus_read(1'b1, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL glitch_event: got %h expected %h", d, 32'h0);
        end
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        quiesce();
        KEY = 4'b1100;
        wait_cycles(SETTLE);
        bus_read(1'b1, d);
        checks++;
        if (d !== 32'h3) begin
            failures++;
            $display("FAIL w1c_setup: got %h expected %h", d, 32'h3);
        end
        bus_write(1'b1, 32'h1);
        bus_read(1'b1, d);
        checks++;
        if (d !== 32'h2) begin
            failures++;
            $display("FAIL w1c_clear: got %h expected %h", d, 32'h2);
        end
        bus_write(1'b0, 32'hFF);
        bus_read(1'b1, d);
        checks++;
        if (d !== 32'h2) begin
            failures++;
            $display("FAIL w1c_addr0_ignored: got %h expected %h", d, 32'h2);
        end
    endtask

    task automatic test_same_cycle_clear();
        logic [31:0] d;
        int          seen;
        quiesce();
        seen = 0;
        write_enable = 1'b1;
        read_enable  = 1'b1;
        address      = 1'b1;
        write_data   = 32'h2;
        KEY          = 4'b1101;
        for (int i = 0; i < 40; i++) begin
            step();
            if (read_data[1]) seen++;
        end
        write_enable = 1'b0;
        read_enable  = 1'b0;
        write_data   = '0;
        checks++;
        if (seen != 1) begin
            failures++;
            $display("FAIL same_cycle_event_wins: got %0d cycles with bit1 expected %0d", seen, 1);
        end
        bus_read(1'b1, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL same_cycle_after: got %h expected %h", d, 32'h0);
        end
    endtask

    task automatic test_release();
        logic [31:0] d;
        logic [31:0] exp;
`ifdef RELEASE_EVENT_EN
        exp = 32'h40;
`else
        exp = 32'h0;
`endif
        quiesce();
        KEY = 4'b1011;
        wait_cycles(SETTLE);
        KEY = 4'hF;
        wait_cycles(SETTLE);
        bus_write(1'b1, 32'h0F);
        bus_read(1'b1, d);
        checks++;
        if (d !== exp) begin
            failures++;
            $display("FAIL release_event: got %h expected %h", d, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        SW = 18'h00F0F;
        quiesce();
        KEY = 4'b1110;
        wait_cycles(SETTLE);
        bus_write(1'b1, 32'hFF);
        bus_read(1'b1, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL midreset_cleared: got %h expected %h", d, 32'h0);
        end
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        bus_read(1'b1, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL midreset_event_zero: got %h expected %h", d, 32'h0);
        end
        wait_cycles(SETTLE);
        bus_read(1'b1, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL midreset_fresh_press: got %h expected %h", d, 32'h1);
        end
        bus_read(1'b0, d);
        checks++;
        if (d !== 32'h00040F0F) begin
            failures++;
            $display("FAIL midreset_level: got %h expected %h", d, 32'h00040F0F);
        end
    endtask

    // Reference model: settled input values plus sticky event sets.
    task automatic test_random();
        logic [31:0] d;
        logic [31:0] exp;
        logic [17:0] m_sw, new_sw;
        logic [3:0]  m_key, new_pressed, m_press, m_release;
        logic [7:0]  clr;
        int          k;
        SW = '0;
        quiesce();
        m_sw = '0;
        m_key = '0;
        m_press = '0;
        m_release = '0;
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                k = $urandom_range(3, 0);
                KEY[k] = ~KEY[k];
                wait_cycles($urandom_range(5, 1));
                KEY[k] = ~KEY[k];
                k = $urandom_range(17, 0);
                SW[k] = ~SW[k];
                wait_cycles($urandom_range(5, 1));
                SW[k] = ~SW[k];
            end
            new_sw      = 18'($urandom);
            new_pressed = 4'($urandom);
            SW  = new_sw;
            KEY = ~new_pressed;
            wait_cycles(SETTLE);
            m_press = m_press | (new_pressed & ~m_key);
`ifdef RELEASE_EVENT_EN
            m_release = m_release | (~new_pressed & m_key);
`endif
            m_key = new_pressed;
            m_sw  = new_sw;

            exp = {10'b0, m_key, m_sw};
            bus_read(1'b0, d);
            checks++;
            if (d !== exp) begin
                failures++;
                $display("FAIL rand_level it%0d: got %h expected %h", it, d, exp);
            end
            exp = {24'b0, m_release, m_press};
            bus_read(1'b1, d);
            checks++;
            if (d !== exp) begin
                failures++;
                $display("FAIL rand_event it%0d: got %h expected %h", it, d, exp);
            end
            clr = 8'($urandom);
            bus_write(1'b1, {24'($urandom), clr});
            m_press   = m_press & ~clr[3:0];
            m_release = m_release & ~clr[7:4];
            exp = {24'b0, m_release, m_press};
            bus_read(1'b1, d);
            checks++;
            if (d !== exp) begin
                failures++;
                $display("FAIL rand_clear it%0d: got %h expected %h", it, d, exp);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        SW           = '0;
        KEY          = 4'hF;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        address      = 1'b0;
        write_data   = '0;
        test_reset();
        test_switch_capture();
        test_bouncy_press();
        test_glitch();
        test_w1c();
        test_same_cycle_clear();
        test_release();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
